// File: rtl/move_wide_seq_pkg.sv
// Shared opcodes, ALU codes, control-word layout and FSM state encodings
// for the move-wide (MOVZ/MOVN/MOVK) sequencer.
package mw_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CW_W    = 31;

  // Opcodes in their 64-bit (sf=1) form; bit 8 selects register width.
  localparam logic [8:0] OP_MOVK = 9'b111100101;
  localparam logic [8:0] OP_MOVZ = 9'b110100101;
  localparam logic [8:0] OP_MOVN = 9'b100100101;

  localparam logic [4:0] ALU_AND     = 5'b000_00;
  localparam logic [4:0] ALU_OR      = 5'b001_00;
  localparam logic [4:0] ALU_OR_NOTB = 5'b001_10;

  localparam logic [4:0] REG_ZR = 5'd31;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;

  // Control-word field widths and bit offsets (LSB position).
  localparam int unsigned CW_ALU_FS_W   = 5;
  localparam int unsigned CW_REG_W      = 5;
  localparam int unsigned CW_PC_FS_W    = 2;
  localparam int unsigned CW_ALU_EN_O   = 30;
  localparam int unsigned CW_ALU_BS_O   = 29;
  localparam int unsigned CW_ALU_FS_O   = 24;
  localparam int unsigned CW_RF_B_EN_O  = 23;
  localparam int unsigned CW_RF_SA_O    = 18;
  localparam int unsigned CW_RF_SB_O    = 13;
  localparam int unsigned CW_RF_DA_O    = 8;
  localparam int unsigned CW_RF_W_O     = 7;
  localparam int unsigned CW_RAM_EN_O   = 6;
  localparam int unsigned CW_RAM_W_O    = 5;
  localparam int unsigned CW_PC_EN_O    = 4;
  localparam int unsigned CW_PC_FS_O    = 2;
  localparam int unsigned CW_PC_IS_O    = 1;
  localparam int unsigned CW_STATUS_O   = 0;

  typedef struct packed {
    logic                   alu_en;
    logic                   alu_bs;
    logic [CW_ALU_FS_W-1:0] alu_fs;
    logic                   rf_b_en;
    logic [CW_REG_W-1:0]    rf_sa;
    logic [CW_REG_W-1:0]    rf_sb;
    logic [CW_REG_W-1:0]    rf_da;
    logic                   rf_w;
    logic                   ram_en;
    logic                   ram_w;
    logic                   pc_en;
    logic [CW_PC_FS_W-1:0]  pc_fs;
    logic                   pc_is;
    logic                   status_ld;
  } cw_t;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MASK  = 3'd1;
  localparam logic [2:0] ST_MERGE = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_ILL   = 3'd4;

endpackage

// File: rtl/move_wide_seq_if.sv
// Instruction handshake and control-word output bundle of the sequencer.
interface move_wide_seq_if #(
  parameter int unsigned DATA_W = 64
);
  logic [31:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic             stall;
  mw_pkg::cw_t      cw;
  logic [DATA_W-1:0] K;
  logic             done;
  logic             illegal;

  modport master (
    output instr, instr_valid, stall,
    input  instr_ready, cw, K, done, illegal
  );

  modport slave (
    input  instr, instr_valid, stall,
    output instr_ready, cw, K, done, illegal
  );
endinterface

// File: rtl/move_wide_seq_k_gen.sv
// Lane-shifted immediate and lane-clearing mask for the ALU B constant.
module mw_k_gen #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LANE_W = 16
) (
  input  logic [LANE_W-1:0] imm,
  input  logic [1:0]        hw,
  output logic [DATA_W-1:0] sh,
  output logic [DATA_W-1:0] mask
);
  localparam int unsigned LANES = DATA_W / LANE_W;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign sh[l*LANE_W +: LANE_W]   = (hw == 2'(l)) ? imm : '0;
    assign mask[l*LANE_W +: LANE_W] = (hw == 2'(l)) ? '0 : '1;
  end
endmodule

// File: rtl/move_wide_seq.sv
// Sequencer turning MOVZ/MOVN/MOVK into ALU/register-file control words;
// MOVK is split into an AND-mask pass and an OR-merge pass.
module move_wide_seq
  import mw_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LANE_W = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  move_wide_seq_if.slave  bus
);
  localparam int unsigned LANES = DATA_W / LANE_W;

  state_t            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic              ready_q;
  cw_t               cw_q, cw_d;
  logic [DATA_W-1:0] k_q, k_d;
  logic [DATA_W-1:0] sh, mask;
  logic              accept_c;
  logic              is_movn_c;

  // Sort an incoming word into its first execution state.
  function automatic state_t classify(input logic [31:0] w);
    logic [8:0] op;
    logic [1:0] hw;
    logic [8:0] op_n;
    logic       sf_ok;
    op    = w[31:23];
    hw    = w[22:21];
    op_n  = {1'b1, op[7:0]};
    sf_ok = (op[8] == (DATA_W == 64));
    if (!sf_ok || 32'(hw) >= LANES) return ST_ILL;
    if (op_n == OP_MOVK) return ST_MASK;
    if (op_n == OP_MOVZ || op_n == OP_MOVN) return ST_EXEC;
    return ST_ILL;
  endfunction

  assign bus.instr_ready = ready_q & ~bus.stall;
  assign accept_c        = bus.instr_valid & bus.instr_ready;

  // Next state and next latched instruction; stall freezes both.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    if (!bus.stall) begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            instr_d = bus.instr;
            state_d = classify(bus.instr);
          end
        end
        ST_MASK: state_d = ST_MERGE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  mw_k_gen #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_k_gen (
    .imm  (LANE_W'(instr_d[20:5])),
    .hw   (instr_d[22:21]),
    .sh   (sh),
    .mask (mask)
  );

  assign is_movn_c = ({1'b1, instr_d[30:23]} == OP_MOVN);

  // Control word for the state being entered, so the registered outputs
  // line up with the state register.
  always_comb begin
    cw_d = '0;
    k_d  = '0;
    case (state_d)
      ST_MASK: begin
        cw_d.alu_en = 1'b1;
        cw_d.alu_bs = 1'b1;
        cw_d.alu_fs = ALU_AND;
        cw_d.rf_sa  = instr_d[4:0];
        cw_d.rf_sb  = REG_ZR;
        cw_d.rf_da  = instr_d[4:0];
        cw_d.rf_w   = 1'b1;
        cw_d.pc_fs  = PC_HOLD;
        k_d         = mask;
      end
      ST_MERGE: begin
        cw_d.alu_en = 1'b1;
        cw_d.alu_bs = 1'b1;
        cw_d.alu_fs = ALU_OR;
        cw_d.rf_sa  = instr_d[4:0];
        cw_d.rf_sb  = REG_ZR;
        cw_d.rf_da  = instr_d[4:0];
        cw_d.rf_w   = 1'b1;
        cw_d.pc_fs  = PC_INC;
        k_d         = sh;
      end
      ST_EXEC: begin
        cw_d.alu_en = 1'b1;
        cw_d.alu_bs = 1'b1;
        cw_d.alu_fs = is_movn_c ? ALU_OR_NOTB : ALU_OR;
        cw_d.rf_sa  = REG_ZR;
        cw_d.rf_sb  = REG_ZR;
        cw_d.rf_da  = instr_d[4:0];
        cw_d.rf_w   = 1'b1;
        cw_d.pc_fs  = PC_INC;
        k_d         = sh;
      end
      default: begin
        cw_d = '0;
        k_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      ready_q <= 1'b0;
      cw_q    <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ready_q <= (state_d == ST_IDLE);
      cw_q    <= cw_d;
      k_q     <= k_d;
    end
  end

  assign bus.cw      = cw_q;
  assign bus.K       = k_q;
  assign bus.done    = ((state_q == ST_MERGE) || (state_q == ST_EXEC)) & ~bus.stall;
  assign bus.illegal = (state_q == ST_ILL) & ~bus.stall;

endmodule

// File: tb/tb_move_wide_seq.sv
// Directed bench for move_wide_seq: 64-bit and 32-bit instances side by side.
module tb_move_wide_seq;
  import mw_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  always #5 clock = ~clock;

  move_wide_seq_if #(.DATA_W(64)) b64 ();
  move_wide_seq_if #(.DATA_W(32)) b32 ();

  move_wide_seq #(.DATA_W(64), .LANE_W(16)) dut64 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b64)
  );

  move_wide_seq #(.DATA_W(32), .LANE_W(16)) dut32 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b32)
  );

  localparam logic [8:0] OP32_MOVZ = 9'b010100101;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected control word for an active ALU pass.
  function automatic logic [63:0] exp_cw(input logic [4:0] fs, input logic [4:0] sa,
                                         input logic [4:0] da, input logic [1:0] pcfs);
    logic [30:0] w;
    w = {1'b1, 1'b1, fs, 1'b0, sa, 5'd31, da, 1'b1, 1'b0, 1'b0, 1'b0, pcfs, 1'b0, 1'b0};
    return 64'(w);
  endfunction

  function automatic logic [31:0] enc(input logic [8:0] op, input logic [1:0] hw,
                                      input logic [15:0] imm, input logic [4:0] rd);
    return {op, hw, imm, rd};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue64(input logic [31:0] w);
    b64.instr       = w;
    b64.instr_valid = 1'b1;
    step();
    b64.instr_valid = 1'b0;
  endtask

  task automatic issue32(input logic [31:0] w);
    b32.instr       = w;
    b32.instr_valid = 1'b1;
    step();
    b32.instr_valid = 1'b0;
  endtask

  initial begin
    b64.instr = '0; b64.instr_valid = 1'b0; b64.stall = 1'b0;
    b32.instr = '0; b32.instr_valid = 1'b0; b32.stall = 1'b0;

    // Held in reset
    #3;
    chk("rst_cw",    64'(b64.cw), 64'h0);
    chk("rst_k",     b64.K, 64'h0);
    chk("rst_ready", 64'(b64.instr_ready), 64'h0);
    chk("rst_done",  64'(b64.done), 64'h0);
    chk("rst_ill",   64'(b64.illegal), 64'h0);
    #14;
    reset_n = 1'b1;
    #1;
    chk("rel_ready_pre", 64'(b64.instr_ready), 64'h0);
    step();
    chk("rel_ready64", 64'(b64.instr_ready), 64'h1);
    chk("rel_ready32", 64'(b32.instr_ready), 64'h1);

    // MOVK X3, #0xBEEF, LSL #32
    issue64(enc(OP_MOVK, 2'd2, 16'hBEEF, 5'd3));
    chk("movk_mask_cw",    64'(b64.cw), exp_cw(ALU_AND, 5'd3, 5'd3, 2'b00));
    chk("movk_mask_k",     b64.K, 64'hFFFF0000FFFFFFFF);
    chk("movk_mask_done",  64'(b64.done), 64'h0);
    chk("movk_mask_ready", 64'(b64.instr_ready), 64'h0);
    step();
    chk("movk_merge_cw",   64'(b64.cw), exp_cw(ALU_OR, 5'd3, 5'd3, 2'b01));
    chk("movk_merge_k",    b64.K, 64'h0000BEEF00000000);
    chk("movk_merge_done", 64'(b64.done), 64'h1);
    step();
    chk("movk_idle_cw",    64'(b64.cw), 64'h0);
    chk("movk_idle_ready", 64'(b64.instr_ready), 64'h1);
    chk("movk_idle_done",  64'(b64.done), 64'h0);

    // MOVZ X7, #0x1234, LSL #16
    issue64(enc(OP_MOVZ, 2'd1, 16'h1234, 5'd7));
    chk("movz_cw",   64'(b64.cw), exp_cw(ALU_OR, 5'd31, 5'd7, 2'b01));
    chk("movz_k",    b64.K, 64'h0000000012340000);
    chk("movz_done", 64'(b64.done), 64'h1);
    step();
    chk("movz_ready", 64'(b64.instr_ready), 64'h1);

    // MOVN X1, #0
    issue64(enc(OP_MOVN, 2'd0, 16'h0000, 5'd1));
    chk("movn_cw",   64'(b64.cw), exp_cw(ALU_OR_NOTB, 5'd31, 5'd1, 2'b01));
    chk("movn_k",    b64.K, 64'h0);
    chk("movn_done", 64'(b64.done), 64'h1);
    step();

    // MOVZ X9, #0xABCD, LSL #48 (top lane)
    issue64(enc(OP_MOVZ, 2'd3, 16'hABCD, 5'd9));
    chk("movz_hw3_k",  b64.K, 64'hABCD000000000000);
    chk("movz_hw3_cw", 64'(b64.cw), exp_cw(ALU_OR, 5'd31, 5'd9, 2'b01));
    step();

    // Unallocated opcode on the 64-bit block
    issue64(enc(9'b101100101, 2'd0, 16'h1111, 5'd4));
    chk("ill64_cw",   64'(b64.cw), 64'h0);
    chk("ill64_k",    b64.K, 64'h0);
    chk("ill64_ill",  64'(b64.illegal), 64'h1);
    chk("ill64_done", 64'(b64.done), 64'h0);
    step();
    chk("ill64_ill_after", 64'(b64.illegal), 64'h0);
    chk("ill64_ready",     64'(b64.instr_ready), 64'h1);

    // 32-bit form of MOVZ on the 64-bit block
    issue64(enc(OP32_MOVZ, 2'd0, 16'h2222, 5'd4));
    chk("ill64_sf_ill", 64'(b64.illegal), 64'h1);
    step();

    // 32-bit block: MOVZ with hw=2 is out of range
    issue32(enc(OP32_MOVZ, 2'd2, 16'h1234, 5'd6));
    chk("ill32_hw_cw",  64'(b32.cw), 64'h0);
    chk("ill32_hw_ill", 64'(b32.illegal), 64'h1);
    chk("ill32_hw_k",   64'(b32.K), 64'h0);
    step();

    // 32-bit block: legal MOVZ W2, #0x5678, LSL #16
    issue32(enc(OP32_MOVZ, 2'd1, 16'h5678, 5'd2));
    chk("movz32_cw",   64'(b32.cw), exp_cw(ALU_OR, 5'd31, 5'd2, 2'b01));
    chk("movz32_k",    64'(b32.K), 64'h56780000);
    chk("movz32_done", 64'(b32.done), 64'h1);
    step();

    // 32-bit block: sf=1 opcode rejected
    issue32(enc(OP_MOVZ, 2'd0, 16'h0001, 5'd2));
    chk("ill32_sf_ill", 64'(b32.illegal), 64'h1);
    step();

    // MOVK X5, #0x00FF with stall held three cycles in MASK and one in MERGE
    issue64(enc(OP_MOVK, 2'd0, 16'h00FF, 5'd5));
    b64.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_mask_cw",    64'(b64.cw), exp_cw(ALU_AND, 5'd5, 5'd5, 2'b00));
      chk("stall_mask_k",     b64.K, 64'hFFFFFFFFFFFF0000);
      chk("stall_mask_ready", 64'(b64.instr_ready), 64'h0);
    end
    b64.stall = 1'b0;
    step();
    chk("stall_merge_cw", 64'(b64.cw), exp_cw(ALU_OR, 5'd5, 5'd5, 2'b01));
    chk("stall_merge_k",  b64.K, 64'h00000000000000FF);
    b64.stall = 1'b1;
    #1;
    chk("stall_merge_done_held", 64'(b64.done), 64'h0);
    step();
    chk("stall_merge_cw_held", 64'(b64.cw), exp_cw(ALU_OR, 5'd5, 5'd5, 2'b01));
    b64.stall = 1'b0;
    #1;
    chk("stall_merge_done", 64'(b64.done), 64'h1);
    step();
    b64.stall = 1'b1;
    #1;
    chk("stall_idle_ready", 64'(b64.instr_ready), 64'h0);
    b64.stall = 1'b0;
    #1;
    chk("unstall_idle_ready", 64'(b64.instr_ready), 64'h1);
    step();

    // Reset asserted during MERGE
    issue64(enc(OP_MOVK, 2'd1, 16'hCAFE, 5'd8));
    step();
    chk("rmid_merge_cw", 64'(b64.cw), exp_cw(ALU_OR, 5'd8, 5'd8, 2'b01));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rmid_cw",    64'(b64.cw), 64'h0);
    chk("rmid_k",     b64.K, 64'h0);
    chk("rmid_done",  64'(b64.done), 64'h0);
    chk("rmid_ready", 64'(b64.instr_ready), 64'h0);
    #3;
    reset_n = 1'b1;
    step();
    chk("rmid_ready_after", 64'(b64.instr_ready), 64'h1);
    chk("rmid_cw_after",    64'(b64.cw), 64'h0);

    // Back-to-back MOVZ after reset recovery
    issue64(enc(OP_MOVZ, 2'd0, 16'h0042, 5'd31));
    chk("post_rst_cw", 64'(b64.cw), exp_cw(ALU_OR, 5'd31, 5'd31, 2'b01));
    chk("post_rst_k",  b64.K, 64'h42);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/move_wide_seq.md
MOVE_WIDE_SEQ -- requirements
Module: move_wide_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 64, datapath and K width (32 or 64).
REQ-002 SHALL have parameter LANE_W, default 16, immediate lane width; LANES = DATA_W/LANE_W.
REQ-003 SHALL have port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port instr, input, 32, instruction word {op[8:0], hw[1:0], imm[15:0], Rd[4:0]}.
REQ-006 SHALL have port instr_valid, input, 1, instr is offered.
REQ-007 SHALL have port instr_ready, output, 1, block can accept instr this cycle.
REQ-008 SHALL have port stall, input, 1, freezes state, outputs, and the latched instruction.
REQ-009 SHALL have port cw, output, 31, control word {alu_en, alu_bs, alu_fs[4:0], rf_b_en, rf_sa[4:0], rf_sb[4:0], rf_da[4:0], rf_w, ram_en, ram_w, pc_en, pc_fs[1:0], pc_is, status_ld}.
REQ-010 SHALL have port K, output, DATA_W, constant driven to ALU B.
REQ-011 SHALL have port done, output, 1, one-cycle pulse on the final cycle of an instruction.
REQ-012 SHALL have port illegal, output, 1, one-cycle pulse when a rejected instruction is retired.

Function
REQ-013 SHALL implement states IDLE, MASK, MERGE, EXEC, ILL.
REQ-014 SHALL assert instr_ready only in IDLE; accept = instr_valid & instr_ready; latch instr on accept.
REQ-015 SHALL transition on accept: MOVK (op 9'b111100101) -> MASK; MOVZ (9'b110100101) -> EXEC; MOVN (9'b100100101) -> EXEC.
REQ-016 SHALL treat as illegal, and transition on accept to ILL: any other op; hw>=LANES; op[8]=1 when DATA_W=32.
REQ-017 SHALL transition MASK -> MERGE, and MERGE, EXEC, ILL -> IDLE, each after one unstalled cycle.
REQ-018 SHALL hold the state unchanged in any cycle where stall=1.
REQ-019 SHALL compute sh = imm zero-extended and shifted left by hw*LANE_W; SHALL compute mask = all-ones with lane hw cleared.
REQ-020 SHALL output in IDLE and ILL: cw = all-zero (NOP: rf_w=0, pc_fs=00), K = 0.
REQ-021 SHALL output in MASK: K = mask; alu_fs = 000_00 (A&B); rf_sa = Rd; rf_da = Rd; rf_w = 1; pc_fs = 00.
REQ-022 SHALL output in MERGE: K = sh; alu_fs = 001_00 (A|B); rf_sa = Rd; rf_da = Rd; rf_w = 1; pc_fs = 01.
REQ-023 SHALL output in EXEC for MOVZ: K = sh; alu_fs = 001_00; rf_sa = 31 (zero register); rf_da = Rd; rf_w = 1; pc_fs = 01.
REQ-024 SHALL output in EXEC for MOVN: K = sh; alu_fs = 001_10 (A|~B); rf_sa = 31; rf_da = Rd; rf_w = 1; pc_fs = 01.
REQ-025 SHALL drive, in all non-IDLE/ILL states: alu_en = 1, alu_bs = 1, rf_sb = 31, and rf_b_en, ram_en, ram_w, pc_en, pc_is, status_ld = 0.
REQ-026 SHALL pulse done in MERGE and EXEC on unstalled cycles; SHALL pulse illegal in ILL on an unstalled cycle; ILL SHALL write no register and SHALL not advance the PC.
REQ-027 SHALL drive cw and K as registered-state-decoded (Moore) outputs: no combinational path from instr or instr_valid to cw or K.
REQ-028 SHALL give latency from accept to the first cw: 1 cycle; SHALL give throughput: MOVZ/MOVN 2 cycles, MOVK 3 cycles, plus stall cycles.
REQ-029 SHALL, when Rd=31, still write (destination handled by the register file).

Reset
REQ-030 SHALL, on reset_n low (any time, including mid-MOVK), go immediately to IDLE: cw = 0, K = 0, done = 0, illegal = 0, instr_ready = 0 while reset_n is low; latched instruction cleared.
REQ-031 SHALL assert instr_ready on the first clock edge after reset_n deasserts (IDLE).

Structure
REQ-032 SHALL place in shared package mw_pkg: opcode constants, ALU function codes (AND, OR, OR_NOTB), control-word field widths/offsets, and the state enum.
REQ-033 SHALL use sub-module mw_k_gen (params DATA_W, LANE_W; in imm, hw; out sh, mask), purely combinational.

Verification
REQ-034 SHALL cover: MOVK X3, #0xBEEF, LSL#32 -> MASK: K=0xFFFF0000FFFFFFFF, fs=00000, rf_da=3; MERGE: K=0x0000BEEF00000000, fs=00100, pc_fs=01, done=1.
REQ-035 SHALL cover: MOVZ X7, #0x1234, LSL#16 -> one EXEC cycle: K=0x0000000012340000, rf_sa=31, fs=00100, done=1.
REQ-036 SHALL cover: MOVN X1, #0x0, hw=0 -> EXEC: K=0, fs=00110 (Rd becomes all-ones).
REQ-037 SHALL cover: DATA_W=32 with a MOVZ using hw=2 -> ILL: cw=0, illegal=1, no rf_w.
REQ-038 SHALL cover: MOVK with stall=1 for 3 cycles in MASK -> cw and K held; MERGE follows after stall drops.
REQ-039 SHALL cover: reset_n low during MERGE -> cw=0 asynchronously, IDLE, instr_ready=1 one cycle after release.
